// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The StChk state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned CNT_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StData,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes little-endian into instruction words and pulses
// word_valid_o for one cycle once the last byte of a word has been taken.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic [CNT_W-1:0]   byte_cnt_o,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [INSTR_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               word_valid_q, word_valid_d;

  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (byte_valid_i) begin
      // Newest byte enters at the top, so the first byte ends up in bits 7:0.
      word_d       = {byte_i, word_q[INSTR_W-1:8]};
      cnt_d        = cnt_q + CNT_W'(1);
      word_valid_d = (cnt_q == CNT_W'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q       <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory, core held in reset
// until loaded. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W:0] DepthLimit = MEM_DEPTH[ADDR_W:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  byte_cnt;
  logic              accept;
  logic              byte_en;
  logic              last_byte;
  logic [ADDR_W:0]   word_count;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
`else
  logic last_q, last_d;
`endif

  always_comb begin
    case (state_q)
      StIdle, StData: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StChk:          in_ready = 1'b1;
`endif
      default:        in_ready = 1'b0;
    endcase
  end

  // A byte presented alongside reload is never taken.
  assign accept = in_valid & in_ready & ~reload;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign byte_en = accept && (state_q == StData);
`else
  // Surplus bytes after the final data byte are consumed and dropped.
  assign byte_en = accept && (state_q == StData) && !last_q;
`endif

  assign last_byte  = byte_en && (byte_cnt == CNT_W'(WORD_BYTES - 1)) && (addr_q == len_q);
  assign word_count = {1'b0, in_data} + 1'b1;

  program_loader_word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (reload),
    .byte_valid_i (byte_en),
    .byte_i       (in_data),
    .byte_cnt_o   (byte_cnt),
    .word_valid_o (mem_we),
    .word_o       (mem_wdata)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`else
    last_d  = last_q;
`endif

    // Address advances after each write except the final one.
    if (mem_we && (addr_q != len_q)) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          len_d   = in_data;
          addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`else
          last_d  = 1'b0;
`endif
          state_d = (word_count > DepthLimit) ? StError : StData;
        end
      end
      StData: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (byte_en) xor_d = xor_q ^ in_data;
        if (last_byte) state_d = StChk;
`else
        if (last_byte) last_d = 1'b1;
        // Release one cycle after the final write strobe has dropped.
        if (last_q && !mem_we) state_d = StDone;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (in_data == xor_q) ? StDone : StError;
      end
`endif
      default: ;
    endcase

    if (reload) begin
      state_d = StIdle;
      len_d   = '0;
      addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_d   = '0;
`else
      last_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      addr_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`else
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`else
      last_q  <= last_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign core_rst = (state_q != StDone);
  assign done     = (state_q == StDone);
  assign error    = (state_q == StError);

endmodule
